// File: rtl/fm_link_pkg.sv
// Shared definitions for the FM sample link: UART FSM states, line levels,
// frame geometry and the byte-order convention used by both ends.
package fm_link_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_t;

    localparam logic UART_IDLE  = 1'b1;
    localparam logic UART_START = 1'b0;
    localparam logic UART_STOP  = 1'b1;

    localparam int unsigned FRAME_BITS = 10;
    localparam int unsigned BYTE_BITS  = 8;

    // Samples travel most-significant byte first; the receiving demux
    // reassembles by shifting each new byte in from the bottom.
    localparam bit MSB_BYTE_FIRST = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// Fractional baud generator: a phase accumulator that adds uartRate every
// running cycle and wraps at clockRate, emitting one tick per wrap.
module uart_baud_tick #(
    parameter int unsigned clockRate = 76_800_000,
    parameter int unsigned uartRate  = 12_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic tick
);

    if (2 * uartRate > clockRate) begin : g_rate_check
        $error("uart_baud_tick: 2*uartRate must not exceed clockRate");
    end

    // acc stays below clockRate and uartRate <= clockRate/2, so acc+uartRate
    // always fits in one extra bit.
    localparam int unsigned W = $clog2(clockRate) + 1;
    localparam logic [W-1:0] CR = W'(clockRate);
    localparam logic [W-1:0] UR = W'(uartRate);

    logic [W-1:0] acc;
    logic [W-1:0] sum;
    logic         wrap;

    assign sum  = acc + UR;
    assign wrap = (sum >= CR);
    assign tick = run && wrap;

    // Accumulator: cleared on accept, advanced only while a frame is running.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (run) begin
            acc <= wrap ? (sum - CR) : sum;
        end
    end

endmodule

// File: rtl/sample_uart_tx.sv
// Serialises an 8*blockSize-bit sample into back-to-back 8N1 UART frames,
// most-significant byte first, with fractional baud timing.
module sample_uart_tx
    import fm_link_pkg::*;
#(
    parameter int unsigned clockRate = 76_800_000,
    parameter int unsigned uartRate  = 12_000_000,
    parameter int unsigned blockSize = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [8*blockSize-1:0]   inData,
    input  logic                     inValid,
    output logic                     inReady,
    output logic                     uart,
    output logic                     busy
);

    localparam int unsigned SW  = BYTE_BITS * blockSize;
    localparam int unsigned BCW = (blockSize > 1) ? $clog2(blockSize) : 1;

    uart_state_t    state, state_d;
    logic [SW-1:0]  shift, shift_d;
    logic [BCW-1:0] byte_cnt, byte_cnt_d;
    logic [2:0]     bit_cnt, bit_cnt_d;
    logic [7:0]     byte_d;
    logic           uart_d;
    logic           accept;
    logic           tick;

    assign accept = inValid && (state == S_IDLE);

    uart_baud_tick #(
        .clockRate (clockRate),
        .uartRate  (uartRate)
    ) u_baud (
        .clk   (clk),
        .reset (reset),
        .clear (accept),
        .run   (busy),
        .tick  (tick)
    );

    // State, datapath and line register; reset idles the line immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            shift    <= '0;
            byte_cnt <= '0;
            bit_cnt  <= '0;
            uart     <= UART_IDLE;
        end else begin
            state    <= state_d;
            shift    <= shift_d;
            byte_cnt <= byte_cnt_d;
            bit_cnt  <= bit_cnt_d;
            uart     <= uart_d;
        end
    end

    // Next-state and datapath updates, advancing only on baud ticks.
    always_comb begin
        state_d    = state;
        shift_d    = shift;
        byte_cnt_d = byte_cnt;
        bit_cnt_d  = bit_cnt;
        unique case (state)
            S_IDLE: begin
                if (inValid) begin
                    shift_d    = inData;
                    byte_cnt_d = BCW'(blockSize - 1);
                    bit_cnt_d  = '0;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    bit_cnt_d = '0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (bit_cnt == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (byte_cnt == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        shift_d    = MSB_BYTE_FIRST ? (shift << BYTE_BITS) : (shift >> BYTE_BITS);
                        byte_cnt_d = byte_cnt - BCW'(1);
                        state_d    = S_START;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs and the line level to register for the next state.
    // The line is computed from next-state values so the registered output
    // lines up with the state it belongs to.
    always_comb begin
        inReady = (state == S_IDLE);
        busy    = !inReady;
        byte_d  = MSB_BYTE_FIRST ? shift_d[SW-1 -: 8] : shift_d[7:0];
        uart_d  = UART_IDLE;
        unique case (state_d)
            S_IDLE:  uart_d = UART_IDLE;
            S_START: uart_d = UART_START;
            S_DATA:  uart_d = byte_d[bit_cnt_d];
            S_STOP:  uart_d = UART_STOP;
            default: uart_d = UART_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sample_uart_tx.sv
// Directed bench for sample_uart_tx: integer-ratio and fractional-ratio
// instances, checked cycle by cycle against hand-derived line patterns.
module tb_sample_uart_tx;
    import fm_link_pkg::*;

    logic        clk;
    logic        a_rst, a_valid, a_ready, a_uart, a_busy;
    logic [23:0] a_data;
    logic        b_rst, b_valid, b_ready, b_uart, b_busy;
    logic [7:0]  b_data;

    int unsigned n_cmp;
    int unsigned n_err;

    sample_uart_tx #(.clockRate(4), .uartRate(1), .blockSize(3)) dut_a (
        .clk     (clk),
        .reset   (a_rst),
        .inData  (a_data),
        .inValid (a_valid),
        .inReady (a_ready),
        .uart    (a_uart),
        .busy    (a_busy)
    );

    sample_uart_tx #(.clockRate(32), .uartRate(5), .blockSize(1)) dut_b (
        .clk     (clk),
        .reset   (b_rst),
        .inData  (b_data),
        .inValid (b_valid),
        .inReady (b_ready),
        .uart    (b_uart),
        .busy    (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected line level k cycles after the first start-bit cycle.
    function automatic logic line_bit(input logic [23:0] data, input int unsigned nbytes,
                                      input int unsigned ratio, input int unsigned k);
        int unsigned bit_idx, byte_i, pos;
        logic [23:0] sh;
        logic [7:0]  b;
        bit_idx = k / ratio;
        byte_i  = bit_idx / FRAME_BITS;
        pos     = bit_idx % FRAME_BITS;
        sh      = data >> (8 * (nbytes - 1 - byte_i));
        b       = sh[7:0];
        if (pos == 0) return 1'b0;
        if (pos == FRAME_BITS - 1) return 1'b1;
        return b[pos-1];
    endfunction

    // Called on the first start-bit cycle; returns on cycle 120 after it.
    task automatic check_sample_a(input logic [23:0] data, input string tag, input bit poke);
        for (int unsigned k = 0; k < 120; k++) begin
            check({tag, "_uart"}, 32'(a_uart), 32'(line_bit(data, 3, 4, k)));
            check({tag, "_busy"}, 32'(a_busy), 32'd1);
            if (poke) begin
                if (k == 10 || k == 60) begin
                    a_valid = 1'b1;
                    a_data  = 24'($urandom);
                end else if (k == 12 || k == 61) begin
                    a_valid = 1'b0;
                    a_data  = 24'($urandom);
                end
            end
            step();
        end
    endtask

    int unsigned dur [10] = '{7, 6, 7, 6, 6, 7, 6, 7, 6, 6};
    logic        lvl [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        a_rst   = 1'b0;
        b_rst   = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_data  = '0;
        b_data  = '0;

        // Reset values
        step();
        step();
        check("rst_a_uart", 32'(a_uart), 32'd1);
        check("rst_a_ready", 32'(a_ready), 32'd1);
        check("rst_a_busy", 32'(a_busy), 32'd0);
        check("rst_b_uart", 32'(b_uart), 32'd1);
        check("rst_b_ready", 32'(b_ready), 32'd1);
        a_rst = 1'b1;
        b_rst = 1'b1;

        // Idle for 100 cycles
        for (int i = 0; i < 100; i++) begin
            step();
            check("idle_uart", 32'(a_uart), 32'd1);
            check("idle_ready", 32'(a_ready), 32'd1);
            check("idle_busy", 32'(a_busy), 32'd0);
            check("idle_b_uart", 32'(b_uart), 32'd1);
        end

        // Single sample 0x123456, with ignored stimulus while busy
        a_data  = 24'h123456;
        a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        check_sample_a(24'h123456, "one", 1'b1);
        check("one_ready_at_120", 32'(a_ready), 32'd1);
        check("one_busy_at_120", 32'(a_busy), 32'd0);
        a_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check("one_quiet_uart", 32'(a_uart), 32'd1);
            check("one_quiet_ready", 32'(a_ready), 32'd1);
        end

        // Back-to-back samples with inValid held high
        a_data  = 24'hFFFFFF;
        a_valid = 1'b1;
        step();
        a_data = 24'h000001;
        check_sample_a(24'hFFFFFF, "b2b1", 1'b0);
        check("b2b_gap_uart", 32'(a_uart), 32'd1);
        check("b2b_gap_ready", 32'(a_ready), 32'd1);
        step();
        a_valid = 1'b0;
        check_sample_a(24'h000001, "b2b2", 1'b0);
        check("b2b_end_ready", 32'(a_ready), 32'd1);

        // Fractional ratio 32/5, single byte 0xA5
        b_data  = 8'hA5;
        b_valid = 1'b1;
        step();
        b_valid = 1'b0;
        for (int unsigned j = 0; j < 10; j++) begin
            for (int unsigned c = 0; c < dur[j]; c++) begin
                check("frac_uart", 32'(b_uart), 32'(lvl[j]));
                check("frac_busy", 32'(b_busy), 32'd1);
                step();
            end
        end
        check("frac_ready_at_64", 32'(b_ready), 32'd1);
        check("frac_uart_idle", 32'(b_uart), 32'd1);
        check("frac_acc_zero", 32'(dut_b.u_baud.acc), 32'd0);

        // Reset during bit 3 of the second byte
        a_data  = 24'h123456;
        a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        for (int unsigned k = 0; k < 57; k++) begin
            check("abort_uart", 32'(a_uart), 32'(line_bit(24'h123456, 3, 4, k)));
            step();
        end
        check("abort_pre_uart", 32'(a_uart), 32'd0);
        a_rst = 1'b0;
        #1;
        check("abort_uart_async", 32'(a_uart), 32'd1);
        check("abort_ready_async", 32'(a_ready), 32'd1);
        step();
        step();
        step();
        a_rst = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            check("abort_after_uart", 32'(a_uart), 32'd1);
            check("abort_after_ready", 32'(a_ready), 32'd1);
            check("abort_after_busy", 32'(a_busy), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sample_uart_tx.md
# sample_uart_tx

Serialises wide modulation samples into 8N1 UART bytes, most-significant byte first, so that a downstream UART receiver and byte demultiplexer can rebuild the original `8*blockSize`-bit sample. It is the sending end of the sample link that feeds the FM transmitter. Test benches, loop-back builds and the capture board use it to stream phase-offset samples. Baud timing comes from a fractional phase accumulator, so `clockRate` need not be an integer multiple of `uartRate`.

## Interface
- `clockRate`, default 76_800_000: `clk` frequency in Hz.
- `uartRate`, default 12_000_000: line bit rate in Hz; `2*uartRate <= clockRate` is required, otherwise elaboration fails.
- `blockSize`, default 3: bytes per sample.
- `clk`, input, 1: the only clock.
- `reset`, input, 1: asynchronous, active-low reset.
- `inData`, input, `8*blockSize`: sample to send.
- `inValid`, input, 1: `inData` is valid.
- `inReady`, output, 1: block can accept a sample.
- `uart`, output, 1: serial line, idle high.
- `busy`, output, 1: a sample is in flight.

## Operation
- States: IDLE, START, DATA, STOP.
- `inReady = (state == IDLE)`, combinational. `busy = !inReady`.
- Accept occurs on a rising edge with `inValid && inReady`. On accept:
  - `inData` is latched into the sample shift register;
  - the byte counter is set to `blockSize-1`;
  - the baud accumulator is cleared;
  - state goes to START.
- Baud tick: the accumulator (width `$clog2(clockRate)+1`) adds `uartRate` on every cycle that is not IDLE.
  - When `acc + uartRate >= clockRate`: `acc <= acc + uartRate - clockRate` and `tick = 1`.
  - Otherwise: `acc <= acc + uartRate`.
- Each bit is held until the next tick.
- START drives `uart = 0`. On tick, state goes to DATA with the bit counter at 0.
- DATA drives the current byte, LSB first.
  - The byte is the top 8 bits of the sample register, so bytes go out MSB-byte first.
  - After bit 7's tick, state goes to STOP.
- STOP drives `uart = 1`. On tick:
  - if the byte counter is 0, state goes to IDLE;
  - otherwise the sample register shifts left by 8, the counter decrements, and state goes to START. No idle gap is inserted between the bytes of one sample.
- `inData` and `inValid` are ignored while not IDLE.

## Timing
- Reset values: `uart = 1`, `inReady = 1`, `busy = 0`, state IDLE, accumulator 0, counters 0.
- Reset takes effect immediately. Asserting reset mid-frame forces `uart` high at once and discards the in-flight sample; no partial byte is completed.
- `uart` is registered. It goes low in the cycle after the accept edge.
- Each bit lasts `floor` or `ceil` of `clockRate/uartRate` cycles. Each frame averages exactly `10*clockRate/uartRate` cycles, with no accumulated drift across a sample.
- After the last stop bit's tick, the block spends one cycle in IDLE. Back-to-back samples are therefore separated by exactly one extra idle-high cycle.
- Sample latency with integer ratio R: `10*blockSize*R` cycles from the cycle after accept to the return to IDLE.

## Structure
- Shared package/header `fm_link_pkg`, holding:
  - state encodings;
  - `UART_IDLE = 1`, `UART_START = 0`, `UART_STOP = 1`;
  - `FRAME_BITS = 10`;
  - the byte-order convention (MSB byte first), also used by the receiving demux.
- One sub-module, `uart_baud_tick`. It contains the fractional accumulator, with ports clk, reset, clear, run, tick. The FSM and shift register stay in the top module.

## Test plan
- Reset, then idle for 100 cycles → `uart = 1`, `inReady = 1`, `busy = 0` throughout.
- `clockRate = 4`, `uartRate = 1`, `blockSize = 3`; one-cycle pulse of `inValid` with `inData = 0x123456` →
  - `uart`, 4 cycles per bit, starting the cycle after accept: `0, 0 1 0 0 1 0 0 0, 1` (byte 0x12);
  - then byte 0x34, then byte 0x56;
  - `inReady` high again 120 cycles after the first start-bit cycle.
- Same configuration, `inValid` held high with 0xFFFFFF then 0x000001 → exactly one idle-high cycle between the two samples; the second sample's first byte is 0x00.
- `clockRate = 32`, `uartRate = 5`, `blockSize = 1`, `inData = 0xA5` →
  - every bit lasts 6 or 7 cycles;
  - the frame ends exactly 64 cycles after the start bit begins;
  - the accumulator is 0 at IDLE.
- Pull `reset` low during bit 3 of the second byte → `uart` goes high in the same cycle, `inReady = 1` after release, and no further line activity occurs until a new accept.
- Toggle `inData` and pulse `inValid` while busy → the transmitted bytes are unchanged and no extra sample is accepted.
